// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the keypad digit loader: FSM state encoding,
//   keypad/BCD sizes and the one-hot helpers used to qualify and encode a
//   single pressed key.
//   Optional feature macro used by the files that import this package:
//   KEYPAD_DEBOUNCE_EN (defined: counted debounce/release; undefined: none).
package keypad_pkg;

    localparam int unsigned NUM_KEYS = 10;
    localparam int unsigned BCD_W    = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        LOAD     = 2'd2,
        HOLD     = 2'd3
    } key_state_t;

    // Exactly one key line set; zero or several keys count as "no key".
    function automatic logic is_onehot(input logic [NUM_KEYS-1:0] k);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (k[i]) ones++;
        end
        return (ones == 1);
    endfunction

    // Bit index of the set key line as a BCD digit (0 when no line is set).
    function automatic logic [BCD_W-1:0] onehot_to_bcd(input logic [NUM_KEYS-1:0] k);
        logic [BCD_W-1:0] bcd;
        bcd = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (k[i]) bcd = BCD_W'(i);
        end
        return bcd;
    endfunction

endpackage

// File: rtl/keypad_debouncer.sv
// keypad_debouncer
//   Synchronises the raw keypad lines, qualifies a single pressed key and,
//   when enabled by the controlling FSM, measures press stability or release
//   quiet time.
//   Feature macro: KEYPAD_DEBOUNCE_EN. Defined: a press must be stable for
//   DEBOUNCE_CYCLES synchronised cycles, a release quiet for DEBOUNCE_CYCLES.
//   Undefined: no counter; a single qualified cycle is enough for either.
// Ports:
//   clock, clearn   clock / asynchronous active-low reset
//   keypad          raw key lines (asynchronous)
//   press_en        FSM is looking for a new key press
//   release_en      FSM is waiting for the keypad to go quiet
//   key_any         synchronised keypad has any line set
//   key_valid       synchronised keypad has exactly one line set
//   stable_key      pulse: press accepted this cycle, code on stable_code
//   stable_code     BCD of the synchronised key
//   released        pulse: keypad quiet long enough this cycle
module keypad_debouncer
    import keypad_pkg::*;
`ifdef KEYPAD_DEBOUNCE_EN
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned CNT_W           = 15
)
`endif
(
    input  logic                clock,
    input  logic                clearn,
    input  logic [NUM_KEYS-1:0] keypad,
    input  logic                press_en,
    input  logic                release_en,
    output logic                key_any,
    output logic                key_valid,
    output logic                stable_key,
    output logic [BCD_W-1:0]    stable_code,
    output logic                released
);

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] k_s;

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            sync1 <= '0;
            k_s   <= '0;
        end else begin
            sync1 <= keypad;
            k_s   <= sync1;
        end
    end

    assign key_any     = |k_s;
    assign key_valid   = is_onehot(k_s);
    assign stable_code = onehot_to_bcd(k_s);

`ifdef KEYPAD_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [CNT_W-1:0]    cnt_inc;
    logic [NUM_KEYS-1:0] cap;
    logic [NUM_KEYS-1:0] cap_next;

    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    // One counter serves both press stability and release quiet time; it is
    // cleared whenever neither is enabled and when a threshold is reached, so
    // every measurement starts from zero on the next state's first cycle.
    always_comb begin
        cnt_next   = '0;
        cap_next   = cap;
        stable_key = 1'b0;
        released   = 1'b0;
        if (press_en) begin
            if (key_valid) begin
                if ((cnt != '0) && (k_s == cap)) begin
                    cnt_next = cnt_inc;
                end else begin
                    cap_next = k_s;
                    cnt_next = CNT_W'(1);
                end
                if (cnt_next >= THRESH) begin
                    stable_key = 1'b1;
                    cnt_next   = '0;
                end
            end
        end else if (release_en) begin
            if (!key_any) begin
                cnt_next = cnt_inc;
                if (cnt_next >= THRESH) begin
                    released = 1'b1;
                    cnt_next = '0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            cnt <= '0;
            cap <= '0;
        end else begin
            cnt <= cnt_next;
            cap <= cap_next;
        end
    end
`else
    assign stable_key = press_en & key_valid;
    assign released   = release_en & ~key_any;
`endif

endmodule

// File: rtl/keypad_digit_loader.sv
// keypad_digit_loader
//   Converts a 10-key decimal keypad into BCD digits with a one-cycle
//   active-low load strobe for the cooking timer. One strobe per accepted
//   press, at most MAX_DIGITS per entry.
//   Feature macro: KEYPAD_DEBOUNCE_EN (defined: counted debounce via the
//   DEBOUNCE state; undefined: press loads the cycle after qualification).
// Ports:
//   clock        system clock, rising edge
//   clearn       asynchronous active-low reset
//   keypad[9:0]  raw key lines, bit i = digit i
//   entry_en     entry permitted (oven idle)
//   clear_entry  synchronous restart of the entry
//   data[3:0]    BCD digit to the timer, holds between strobes
//   loadn        active-low one-cycle load strobe
//   digit_count  digits accepted since last clear/reset
//   full         digit_count has reached MAX_DIGITS
//   key_busy     FSM not in IDLE
module keypad_digit_loader
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned MAX_DIGITS      = 3,
    parameter int unsigned CNT_W           = 15
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic [9:0] keypad,
    input  logic       entry_en,
    input  logic       clear_entry,
    output logic [3:0] data,
    output logic       loadn,
    output logic [1:0] digit_count,
    output logic       full,
    output logic       key_busy
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

    if ((DEBOUNCE_CYCLES < 1) || (CNT_W < 1) ||
        ((CNT_W < 32) && (DEBOUNCE_CYCLES >= (32'd1 << CNT_W))) ||
        (MAX_DIGITS < 1) || (MAX_DIGITS > 3)) begin : g_bad_params
        $error("keypad_digit_loader: invalid parameter set");
    end

    key_state_t       state;
    key_state_t       state_next;
    logic             press_en;
    logic             release_en;
    logic             key_any;
    logic             key_valid;
    logic             stable_key;
    logic [BCD_W-1:0] stable_code;
    logic             released;

    assign press_en   = ~clear_entry & entry_en & ((state == IDLE) | (state == DEBOUNCE));
    assign release_en = ~clear_entry & (state == HOLD);

    keypad_debouncer
`ifdef KEYPAD_DEBOUNCE_EN
    #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    )
`endif
    u_debouncer (
        .clock       (clock),
        .clearn      (clearn),
        .keypad      (keypad),
        .press_en    (press_en),
        .release_en  (release_en),
        .key_any     (key_any),
        .key_valid   (key_valid),
        .stable_key  (stable_key),
        .stable_code (stable_code),
        .released    (released)
    );

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear_entry) begin
            state_next = key_any ? HOLD : IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!entry_en) begin
                        // A key already down when entry is blocked must be
                        // released before it can ever fire.
                        if (key_any) state_next = HOLD;
                    end else if (stable_key) begin
                        state_next = full ? HOLD : LOAD;
                    end
`ifdef KEYPAD_DEBOUNCE_EN
                    else if (key_valid) begin
                        state_next = DEBOUNCE;
                    end
`endif
                end
`ifdef KEYPAD_DEBOUNCE_EN
                DEBOUNCE: begin
                    if (!entry_en)       state_next = HOLD;
                    else if (!key_valid) state_next = IDLE;
                    else if (stable_key) state_next = full ? HOLD : LOAD;
                end
`endif
                LOAD: state_next = HOLD;
                HOLD: if (released) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // loadn is decoded combinationally so a clear in the LOAD cycle or a
    // reset mid-LOAD suppresses the strobe immediately.
    assign loadn    = ~((state == LOAD) & ~clear_entry);
    assign full     = (digit_count == MAX_CNT);
    assign key_busy = (state != IDLE);

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            data        <= '0;
            digit_count <= '0;
        end else if (clear_entry) begin
            data        <= '0;
            digit_count <= '0;
        end else begin
            if (state_next == LOAD) data <= stable_code;
            if ((state == LOAD) && (digit_count != MAX_CNT)) digit_count <= digit_count + 2'd1;
        end
    end

endmodule

// File: tb/tb_keypad_digit_loader.sv
module tb_keypad_digit_loader;

    localparam int unsigned D    = 4;
    localparam int          MAXD = 3;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam int DE = 4;
`else
    localparam int DE = 1;
`endif
    // Bounce pattern: without debounce every 2-cycle burst is its own press.
    localparam int BOUNCE_EXP = (DE == 1) ? 3 : 1;

    logic       clock;
    logic       clearn;
    logic [9:0] keypad;
    logic       entry_en;
    logic       clear_entry;
    logic [3:0] data;
    logic       loadn;
    logic [1:0] digit_count;
    logic       full;
    logic       key_busy;

    keypad_digit_loader #(
        .DEBOUNCE_CYCLES (D),
        .MAX_DIGITS      (MAXD),
        .CNT_W           (15)
    ) dut (
        .clock       (clock),
        .clearn      (clearn),
        .keypad      (keypad),
        .entry_en    (entry_en),
        .clear_entry (clear_entry),
        .data        (data),
        .loadn       (loadn),
        .digit_count (digit_count),
        .full        (full),
        .key_busy    (key_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int strobes;
    int strobe_at;

    // Reference model state
    logic [9:0] m_p1, m_p2, m_code;
    bit m_locked, m_loading;
    int m_run, m_quiet, m_count, m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int bcd_of(input logic [9:0] k);
        for (int i = 0; i < 10; i++) if (k[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_code = '0;
        m_locked = 0; m_loading = 0;
        m_run = 0; m_quiet = 0; m_count = 0; m_data = 0;
    endtask

    task automatic model_update(input logic [9:0] ks);
        if (clear_entry) begin
            m_count = 0; m_data = 0; m_loading = 0; m_run = 0; m_quiet = 0;
            m_locked = (ks != 0);
        end else if (m_loading) begin
            if (m_count < MAXD) m_count++;
            m_loading = 0; m_locked = 1; m_quiet = 0;
        end else if (m_locked) begin
            if (ks == 0) begin
                m_quiet++;
                if (m_quiet >= DE) begin m_locked = 0; m_quiet = 0; end
            end else m_quiet = 0;
        end else if (!entry_en) begin
            if (m_run > 0 || ks != 0) begin m_locked = 1; m_quiet = 0; end
            m_run = 0;
        end else if ($countones(ks) == 1) begin
            if (m_run > 0 && ks == m_code) m_run++;
            else begin m_code = ks; m_run = 1; end
            if (m_run >= DE) begin
                m_run = 0;
                if (m_count == MAXD) begin m_locked = 1; m_quiet = 0; end
                else begin m_loading = 1; m_data = bcd_of(ks); end
            end
        end else m_run = 0;
    endtask

    // Check one cycle at the falling edge, then advance model at the rising edge.
    task automatic step();
        logic [9:0] ks;
        ks = m_p2;
        @(negedge clock);
        chk("loadn", loadn, !(m_loading && !clear_entry));
        chk("data", data, m_data);
        chk("digit_count", digit_count, m_count);
        chk("full", full, (m_count == MAXD));
        chk("key_busy", key_busy, (m_locked || m_loading || m_run > 0));
        if (loadn === 1'b0) begin strobes++; strobe_at = cyc; end
        @(posedge clock);
        model_update(ks);
        m_p2 = m_p1;
        m_p1 = keypad;
        cyc++;
        #1;
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    task automatic press(input int k, input int on_cycles, input int off_cycles);
        keypad = 10'd1 << k;
        hold(on_cycles);
        keypad = '0;
        hold(off_cycles);
    endtask

    task automatic do_clear();
        clear_entry = 1'b1;
        step();
        clear_entry = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_loadn"}, loadn, 1'b1);
        chk({tag, "_data"}, data, 0);
        chk({tag, "_digit_count"}, digit_count, 0);
        chk({tag, "_full"}, full, 1'b0);
        chk({tag, "_key_busy"}, key_busy, 1'b0);
    endtask

    initial begin
        int p;
        int hold_left;
        int r;

        keypad = '0; entry_en = 1'b1; clear_entry = 1'b0; clearn = 1'b0;
        model_reset();
        strobes = 0; strobe_at = 0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("reset");
        @(negedge clock) clearn = 1'b1;
        @(posedge clock);
        #1;

        // Key 7 held: one strobe after sync + debounce latency
        strobes = 0;
        p = cyc;
        keypad = 10'd1 << 7;
        hold(20);
        chk("k7_strobes", strobes, 1);
        chk("k7_latency", strobe_at - p, 2 + DE);
        chk("k7_data", data, 7);
        chk("k7_count", digit_count, 1);
        keypad = '0;
        hold(DE + 6);

        // 1,3,0 fills the entry; a fourth digit is dropped
        do_clear();
        strobes = 0;
        press(1, 10, 10);
        press(3, 10, 10);
        press(0, 10, 10);
        chk("130_strobes", strobes, 3);
        chk("130_data", data, 0);
        chk("130_full", full, 1'b1);
        strobes = 0;
        press(5, 10, 10);
        chk("fourth_strobes", strobes, 0);
        chk("fourth_data", data, 0);
        chk("fourth_count", digit_count, 3);

        // Key 2 bouncing then stable
        do_clear();
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            keypad = ((i % 4) < 2) ? (10'd1 << 2) : 10'd0;
            step();
        end
        keypad = 10'd1 << 2;
        hold(12);
        chk("bounce_strobes", strobes, BOUNCE_EXP);
        chk("bounce_data", data, 2);
        keypad = '0;
        hold(10);

        // Two keys together, then one released
        do_clear();
        strobes = 0;
        keypad = (10'd1 << 3) | (10'd1 << 8);
        hold(10);
        chk("multi_strobes", strobes, 0);
        keypad = 10'd1 << 3;
        hold(12);
        chk("single_strobes", strobes, 1);
        chk("single_data", data, 3);
        keypad = '0;
        hold(10);

        // Key held across entry_en rising never fires
        entry_en = 1'b0;
        strobes = 0;
        keypad = 10'd1 << 9;
        hold(10);
        entry_en = 1'b1;
        hold(10);
        chk("en_held_strobes", strobes, 0);
        keypad = '0;
        hold(10);
        keypad = 10'd1 << 9;
        hold(12);
        chk("en_repress_strobes", strobes, 1);
        chk("en_repress_data", data, 9);
        chk("en_repress_count", digit_count, 2);
        keypad = '0;
        hold(10);

        // Asynchronous reset in the middle of a press
        keypad = 10'd1 << 6;
        hold(3);
        clearn = 1'b0;
        #1;
        check_reset_values("midreset");
        keypad = '0;
        model_reset();
        @(negedge clock) clearn = 1'b1;
        @(posedge clock);
        #1;

        // clear_entry in the LOAD cycle suppresses the strobe
        strobes = 0;
        keypad = 10'd1 << 4;
        hold(2 + DE);
        clear_entry = 1'b1;
        step();
        clear_entry = 1'b0;
        hold(5);
        chk("clrload_strobes", strobes, 0);
        chk("clrload_count", digit_count, 0);
        chk("clrload_data", data, 0);
        chk("clrload_busy", key_busy, 1'b1);
        keypad = '0;
        hold(10);

        // Randomised traffic against the model
        hold_left = 0;
        for (int n = 0; n < 800; n++) begin
            if (hold_left == 0) begin
                r = $urandom_range(0, 9);
                if (r < 4)      keypad = '0;
                else if (r < 9) keypad = 10'd1 << $urandom_range(0, 9);
                else            keypad = 10'($urandom);
                hold_left = $urandom_range(1, 12 + 2 * DE);
            end
            entry_en    = ($urandom_range(0, 19) != 0);
            clear_entry = ($urandom_range(0, 39) == 0);
            step();
            hold_left--;
        end
        clear_entry = 1'b0;
        entry_en = 1'b1;
        keypad = '0;
        hold(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
